// File: rtl/uart_pkg.sv
// Shared UART constants used by blocks that instantiate the FIFO data store.
package uart_pkg;

  localparam int UART_FIFO_POINTER_W = 4;
  localparam int UART_FIFO_DEPTH     = 16;
  localparam int UART_FIFO_DATA_W    = 8;

  // True when a pointer of the given width can address every FIFO entry.
  function automatic bit uart_fifo_ptr_fits(input int ptr_w, input int depth);
    return (64'd1 << ptr_w) >= 64'(depth);
  endfunction

endpackage : uart_pkg

// File: rtl/ram_infr.sv
// Inferred dual-port RAM: one synchronous write port and one asynchronous
// read port. Serves as the data store of the UART RX/TX FIFOs.
// The write address comes from the FIFO top pointer and the read address
// from the bottom pointer. The array clears asynchronously on reset.
module ram_infr #(
  parameter int addr_width = 4,
  parameter int data_width = 8,
  parameter int depth      = 16
) (
  input  logic                  clk,
  input  logic                  wb_rst_ni,
  input  logic                  we,
  input  logic [addr_width-1:0] a,
  input  logic [addr_width-1:0] dpra,
  input  logic [data_width-1:0] di,
  output logic [data_width-1:0] dpo
);

  // Index width needed to select one of the depth words.
  localparam int idx_w = (depth > 1) ? $clog2(depth) : 1;

  // depth as an unsigned value one bit wider than the address. The range
  // check then compares like widths and stays correct when depth == 2**addr_width.
  localparam logic [addr_width:0] depth_c = depth[addr_width:0];

  logic [data_width-1:0] mem_q [depth];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [idx_w-1:0]      wr_idx;
  logic [idx_w-1:0]      rd_idx;

  assign wr_in_range = ({1'b0, a}    < depth_c);
  assign rd_in_range = ({1'b0, dpra} < depth_c);
  assign wr_idx      = a[idx_w-1:0];
  assign rd_idx      = dpra[idx_w-1:0];

  // Async clear of the whole array; otherwise write one in-range word per edge.
  // NOTE: this array is reset on purpose. The FIFO needs every word to read 0
  // after reset. The array therefore maps to flops and never to a RAM macro.
  always_ff @(posedge clk or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && wr_in_range) begin
      // NOTE: sequential state uses non-blocking assignment. Then every
      // reader of mem_q sees the pre-edge value, whatever the process order.
      mem_q[wr_idx] <= di;
    end
  end

  // Combinational read with zero latency and no write bypass. An
  // out-of-range address reads 0.
  assign dpo = rd_in_range ? mem_q[rd_idx] : '0;

endmodule : ram_infr

// File: tb/tb_ram_infr.sv
// Self-checking bench for ram_infr. u0 is the default FIFO configuration
// (4, 8, 16). u1 has a 5-bit address over 16 words, so out-of-range
// accesses are reachable. Expected values come from plain arrays that
// follow the behavioural rules of the RAM.
module tb_ram_infr;
  import uart_pkg::*;

  logic       clk;
  logic       rst_n;

  logic       we0;
  logic [3:0] a0, dpra0;
  logic [7:0] di0, dpo0;

  logic       we1;
  logic [4:0] a1, dpra1;
  logic [7:0] di1, dpo1;

  logic [7:0] model0 [16];
  logic [7:0] model1 [16];

  int checks = 0;
  int errors = 0;

  ram_infr #(UART_FIFO_POINTER_W, UART_FIFO_DATA_W, UART_FIFO_DEPTH) u0 (
    .clk       (clk),
    .wb_rst_ni (rst_n),
    .we        (we0),
    .a         (a0),
    .dpra      (dpra0),
    .di        (di0),
    .dpo       (dpo0)
  );

  ram_infr #(5, 8, 16) u1 (
    .clk       (clk),
    .wb_rst_ni (rst_n),
    .we        (we1),
    .a         (a1),
    .dpra      (dpra1),
    .di        (di1),
    .dpo       (dpo1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read of the 16-word RAM behind the 5-bit address.
  function automatic logic [7:0] exp1(input logic [4:0] ad);
    return (ad < 5'd16) ? model1[ad[3:0]] : 8'h00;
  endfunction

  task automatic write0(input logic [3:0] ad, input logic [7:0] d);
    @(negedge clk);
    a0 = ad; di0 = d; we0 = 1'b1;
    @(posedge clk);
    model0[ad] = d;
    #1 we0 = 1'b0;
  endtask

  task automatic write1(input logic [4:0] ad, input logic [7:0] d);
    @(negedge clk);
    a1 = ad; di1 = d; we1 = 1'b1;
    @(posedge clk);
    if (ad < 5'd16) model1[ad[3:0]] = d;
    #1 we1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    we0 = 1'b0; a0 = '0; dpra0 = '0; di0 = '0;
    we1 = 1'b0; a1 = '0; dpra1 = '0; di1 = '0;
    for (int i = 0; i < 16; i++) begin
      model0[i] = 8'h00;
      model1[i] = 8'h00;
    end

    // Reset state.
    #2;
    for (int i = 0; i < 16; i += 5) begin
      dpra0 = 4'(i); #1 check("reset_state", dpo0, 8'h00);
    end
    @(negedge clk) rst_n = 1'b1;

    // Fill with A5, then assert reset between edges. The clear needs no clock.
    for (int i = 0; i < 16; i++) write0(4'(i), 8'hA5);
    dpra0 = 4'd0; #1 check("prefill_a5", dpo0, 8'hA5);
    @(negedge clk); #1 rst_n = 1'b0;
    #1 check("async_reset_no_clk", dpo0, 8'h00);
    for (int i = 0; i < 16; i++) model0[i] = 8'h00;
    for (int i = 1; i < 16; i++) begin
      dpra0 = 4'(i); #0.5 check("async_reset_sweep", dpo0, 8'h00);
    end
    @(negedge clk) rst_n = 1'b1;

    // Write/read sweep. Each read is checked 0.5 ns after dpra changes.
    for (int i = 0; i < 16; i++) write0(4'(i), 8'(i) ^ 8'h3C);
    for (int i = 0; i < 16; i++) begin
      dpra0 = 4'(i); #0.5 check("sweep", dpo0, 8'(i) ^ 8'h3C);
    end

    // A low we holds the stored word across several edges.
    write0(4'd5, 8'h11);
    @(negedge clk);
    a0 = 4'd5; di0 = 8'hFF; we0 = 1'b0; dpra0 = 4'd5;
    repeat (3) begin
      @(posedge clk); #1 check("we0_hold", dpo0, 8'h11);
    end

    // Read during write at the same address: old word before the edge, new word after.
    write0(4'd7, 8'h22);
    @(negedge clk);
    dpra0 = 4'd7; a0 = 4'd7; di0 = 8'h99; we0 = 1'b1;
    #1 check("rdw_before_edge", dpo0, 8'h22);
    @(posedge clk); model0[7] = 8'h99;
    #1 check("rdw_after_edge", dpo0, 8'h99);
    we0 = 1'b0;

    // Writes to one address leave reads of another address unchanged.
    write0(4'd4, 8'h55);
    @(negedge clk);
    dpra0 = 4'd4; a0 = 4'd3; di0 = 8'h44; we0 = 1'b1;
    @(posedge clk); model0[3] = 8'h44;
    #1 check("diff_addr_hold", dpo0, 8'h55);
    we0 = 1'b0;
    dpra0 = 4'd3; #1 check("diff_addr_new", dpo0, 8'h44);

    // Out-of-range accesses on the 5-bit-address instance.
    for (int i = 0; i < 16; i++) write1(5'(i), 8'h80 + 8'(i));
    write1(5'd20, 8'h77);
    for (int i = 0; i < 32; i++) begin
      dpra1 = 5'(i); #0.5 check("oor_sweep", dpo1, exp1(5'(i)));
    end
    dpra1 = 5'd20; #0.5 check("oor_read_zero", dpo1, 8'h00);

    // Random traffic on both instances, checked against the arrays.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      we0 = 1'($urandom); a0 = 4'($urandom); di0 = 8'($urandom); dpra0 = 4'($urandom);
      we1 = 1'($urandom); a1 = 5'($urandom); di1 = 8'($urandom); dpra1 = 5'($urandom);
      #1;
      check("rand0_pre", dpo0, model0[dpra0]);
      check("rand1_pre", dpo1, exp1(dpra1));
      @(posedge clk);
      if (we0) model0[a0] = di0;
      if (we1 && a1 < 5'd16) model1[a1[3:0]] = di1;
      #1;
      check("rand0_post", dpo0, model0[dpra0]);
      check("rand1_post", dpo1, exp1(dpra1));
    end
    @(negedge clk) we0 = 1'b0; we1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ram_infr
